// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: emulates an OV7670 RGB565 camera stream (pclk/vsync/href/d) with selectable test patterns
module ov7670_stream_gen #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int H_BLANK  = 16,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 2,
  parameter int V_FRONT  = 2
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_count
);
  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int BW   = $clog2(LINE);
  localparam int BAR  = H_ACTIVE / 8;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  state_t state, state_n;
  logic [BW-1:0] byte_cnt;
  logic [15:0] line_cnt, line_max, pix_cnt, bar_px, color_q, pix;
  logic [2:0] bar_idx;
  logic [1:0] mode_q;
  logic tick, eol, eos, start, frame_end, lo_byte, bar_end;
  assign tick     = pclk;
  assign eol      = byte_cnt == BW'(LINE - 1);
  assign line_max = state == VSYNC  ? 16'(V_SYNC - 1)   :
                    state == VBACK  ? 16'(V_BACK - 1)   :
                    state == ACTIVE ? 16'(V_ACTIVE - 1) : 16'(V_FRONT - 1);
  assign eos      = eol && line_cnt == line_max;
  assign vsync    = state == VSYNC;
  assign href     = state == ACTIVE && byte_cnt < BW'(2 * H_ACTIVE);
  assign lo_byte  = href && byte_cnt[0];
  assign bar_end  = lo_byte && bar_px == 16'(BAR - 1);
  assign pix      = mode_q == 2'd1 ? pix_cnt : mode_q == 2'd2 ? color_q : BARS[bar_idx];
  assign d        = !href ? 8'h00 : byte_cnt[0] ? pix[7:0] : pix[15:8];
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Transitions happen only on ticks so every output edge lands on a falling pclk edge
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    frame_end = 1'b0;
    if (tick)
      case (state)
        IDLE: if (enable) begin
          state_n = VSYNC;
          start   = 1'b1;
        end
        VSYNC:  if (eos) state_n = VBACK;
        VBACK:  if (eos) state_n = ACTIVE;
        ACTIVE: if (eos) state_n = VFRONT;
        VFRONT: if (eos) begin
          frame_end = 1'b1;
          start     = enable;
          state_n   = enable ? VSYNC : IDLE;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      pclk        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      byte_cnt    <= '0;
      line_cnt    <= 16'd0;
      pix_cnt     <= 16'd0;
      bar_px      <= 16'd0;
      bar_idx     <= 3'd0;
      mode_q      <= 2'd0;
      color_q     <= 16'd0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 8'd1;
      if (start) begin
        mode_q   <= mode;
        color_q  <= solid_color;
        byte_cnt <= '0;
        line_cnt <= 16'd0;
        pix_cnt  <= 16'd0;
        bar_px   <= 16'd0;
        bar_idx  <= 3'd0;
      end else if (tick && state != IDLE) begin
        byte_cnt <= eol ? '0 : byte_cnt + BW'(1);
        line_cnt <= eos ? 16'd0 : eol ? line_cnt + 16'd1 : line_cnt;
        if (lo_byte) pix_cnt <= pix_cnt + 16'd1;
        bar_px   <= eol || bar_end ? 16'd0 : lo_byte ? bar_px + 16'd1 : bar_px;
        bar_idx  <= eol ? 3'd0 : bar_end ? bar_idx + 3'd1 : bar_idx;
      end
    end
endmodule
